// File: rtl/stack_push_seq.sv
// Push sequencer for CALL / interrupt entry: writes the return address (and flags
// on interrupt) to the data-memory stack low word first, and owns the stack pointer.
module stack_push_seq #(
  parameter int unsigned     W       = 16,
  parameter int unsigned     SIZE    = 20,
  parameter logic [SIZE-1:0] SP_INIT = '1,
  parameter int unsigned     FLAGS_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               call_req,
  input  logic               int_req,
  input  logic [2*W-1:0]     ret_pc,
  input  logic [FLAGS_W-1:0] flags,
  input  logic               pop_inc,
  output logic               mem_we,
  output logic [SIZE-1:0]    mem_addr,
  output logic [W-1:0]       mem_wd,
  output logic               busy,
  output logic               done,
  output logic [SIZE-1:0]    sp,
  output logic               stack_ovf
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PUSH_FL = 2'd1;
  localparam logic [1:0] S_PUSH_LO = 2'd2;
  localparam logic [1:0] S_PUSH_HI = 2'd3;

  logic [1:0]         r_state;
  logic [1:0]         w_state_next;
  logic [SIZE-1:0]    r_sp;
  logic [SIZE-1:0]    w_sp_next;
  logic [2*W-1:0]     r_pc;
  logic [FLAGS_W-1:0] r_flags;
  logic               r_ovf;
  logic               r_done;
  logic               w_we;
  logic               w_accept;

  assign w_we     = (r_state != S_IDLE);
  assign w_accept = (r_state == S_IDLE) && (int_req || call_req);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (int_req)       w_state_next = S_PUSH_FL;
        else if (call_req) w_state_next = S_PUSH_LO;
      end
      S_PUSH_FL: w_state_next = S_PUSH_LO;
      S_PUSH_LO: w_state_next = S_PUSH_HI;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // Writes only happen outside IDLE and pops only inside it, so the two never collide.
  always_comb begin
    w_sp_next = r_sp;
    if (w_we)
      w_sp_next = r_sp - 1'b1;
    else if (pop_inc && !w_accept)
      w_sp_next = r_sp + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sp    <= SP_INIT;
      r_pc    <= '0;
      r_flags <= '0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_sp    <= w_sp_next;
      r_done  <= (r_state == S_PUSH_HI);
      if (w_accept) begin
        r_pc <= ret_pc;
        if (int_req) r_flags <= flags;
      end
      if (w_we && (r_sp == '0)) r_ovf <= 1'b1;
    end
  end

  always_comb begin
    mem_wd = '0;
    case (r_state)
      S_PUSH_FL: mem_wd = {{(W-FLAGS_W){1'b0}}, r_flags};
      S_PUSH_LO: mem_wd = r_pc[W-1:0];
      S_PUSH_HI: mem_wd = r_pc[2*W-1:W];
      default:   mem_wd = '0;
    endcase
  end

  assign mem_we    = w_we;
  assign mem_addr  = r_sp;
  assign busy      = w_we;
  assign done      = r_done;
  assign sp        = r_sp;
  assign stack_ovf = r_ovf;

endmodule
